// File: rtl/generic_down_counter_pkg.sv
// generic_down_counter_pkg: shared state encoding and default sizes for
// BCD-digit and dice-face down-counters.
`default_nettype none

package generic_down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIGIT_WIDTH = 4;
    localparam int DIGIT_MAX   = 9;
    localparam int DICE_WIDTH  = 3;
    localparam int DICE_MAX    = 5;

endpackage

`default_nettype wire

// File: rtl/generic_down_counter.sv
// ============================================================================
//  Module      : generic_down_counter
//  Description : Loadable down-counter with registered borrow pulse and an
//                optional one-shot (stop at zero) mode. Defining
//                GENERIC_DOWN_COUNTER_UPDOWN_EN adds an up_i port for up/down.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module generic_down_counter
    import generic_down_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = DIGIT_WIDTH,
    parameter int COUNTER_MAX   = DIGIT_MAX,
    parameter int ONE_SHOT      = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     load_i,
    input  logic [COUNTER_WIDTH-1:0] load_value_i,
`ifdef GENERIC_DOWN_COUNTER_UPDOWN_EN
    input  logic                     up_i,
`endif
    output logic                     trig_out_o,
    output logic [COUNTER_WIDTH-1:0] count_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);

    if ((COUNTER_MAX < 0) || ((COUNTER_MAX >> COUNTER_WIDTH) != 0)) begin : g_max_check
        $error("generic_down_counter: COUNTER_MAX does not fit in COUNTER_WIDTH");
    end

    state_t                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   count_q, count_d;
    logic                       trig_q, trig_d;
    logic [COUNTER_WIDTH-1:0]   load_clamped;

    assign load_clamped = (load_value_i > MAX_VAL) ? MAX_VAL : load_value_i;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        trig_d  = 1'b0;
        if (load_i) begin
            count_d = load_clamped;
            state_d = ST_RUN;
        end else if (enable_i && (state_q == ST_RUN)) begin
`ifdef GENERIC_DOWN_COUNTER_UPDOWN_EN
            if (up_i) begin
                // Counting up never finishes a one-shot run; carry wraps to 0.
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    trig_d  = 1'b1;
                end else begin
                    count_d = count_q + COUNTER_WIDTH'(1);
                end
            end else
`endif
            begin
                if (count_q != '0) begin
                    count_d = count_q - COUNTER_WIDTH'(1);
                end else begin
                    trig_d = 1'b1;
                    if (ONE_SHOT != 0) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = MAX_VAL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            trig_q  <= 1'b0;
            if (ONE_SHOT != 0) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= ST_RUN;
            end
        end else begin
            count_q <= count_d;
            trig_q  <= trig_d;
            state_q <= state_d;
        end
    end

    assign count_o    = count_q;
    assign trig_out_o = trig_q;
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);

endmodule

`default_nettype wire
